// File: rtl/fp_mult_arb_pkg.sv
// Shared widths and payload types for the FP32 multiplier round-robin arbiter.
package fp_mult_arb_pkg;

    localparam int unsigned FP_W   = 32;
    localparam int unsigned FLAG_W = 3;

    typedef struct packed {
        logic [FP_W-1:0] a;
        logic [FP_W-1:0] b;
    } fp_operands_t;

endpackage

// File: rtl/arb_tag_fifo.sv
// Synchronous tag FIFO remembering which lane owns each in-flight multiply.
module arb_tag_fifo #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push) tail_d = tail_q + 1'b1;
        if (pop)  head_d = head_q + 1'b1;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[tail_q] <= push_data;
    end

    assign head_data = mem_q[head_q];
    assign count     = count_q;
    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);

endmodule

// File: rtl/fp_mult_rr_arbiter.sv
// Round-robin sharing of one latency-insensitive FP32 multiplier among NUM_REQ lanes;
// results are steered back to their issuing lane through an in-order tag FIFO.
module fp_mult_rr_arbiter
    import fp_mult_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned MAX_INFLIGHT = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [FP_W*NUM_REQ-1:0]       req_a,
    input  logic [FP_W*NUM_REQ-1:0]       req_b,
    output logic [NUM_REQ-1:0]            rsp_valid,
    input  logic [NUM_REQ-1:0]            rsp_ready,
    output logic [FP_W-1:0]               rsp_result,
    output logic [FLAG_W-1:0]             rsp_flags,
    output logic [FP_W-1:0]               m_a,
    output logic [FP_W-1:0]               m_b,
    output logic                          m_valid,
    input  logic                          m_ready,
    input  logic [FP_W-1:0]               m_result,
    input  logic [FLAG_W-1:0]             m_flags,
    input  logic                          m_rvalid,
    output logic                          m_rready,
    output logic [$clog2(MAX_INFLIGHT):0] inflight,
    output logic                          err_orphan
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT) + 1;

    typedef logic [IDX_W-1:0] lane_idx_t;

    // First valid lane at or after ptr, scanning upward modulo NUM_REQ.
    function automatic lane_idx_t rr_grant(input logic [NUM_REQ-1:0] valid,
                                           input lane_idx_t          ptr);
        int unsigned lane;
        lane_idx_t   lane_i;
        rr_grant = ptr;
        for (int unsigned k = NUM_REQ; k > 0; k--) begin
            lane   = (32'(ptr) + k - 1) % NUM_REQ;
            lane_i = IDX_W'(lane);
            if (valid[lane_i]) rr_grant = lane_i;
        end
    endfunction

    lane_idx_t        rr_ptr_q, rr_ptr_d;
    lane_idx_t        grant;
    lane_idx_t        tag;
    logic             err_orphan_q, err_orphan_d;
    logic             can_issue, issue_fire, rsp_fire;
    logic             fifo_full, fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    fp_operands_t     grant_ops;

    // Issue side: m_valid is independent of m_ready; a same-cycle pop never frees a slot.
    always_comb begin
        grant      = rr_grant(req_valid, rr_ptr_q);
        can_issue  = (|req_valid) && !fifo_full && !reset;
        issue_fire = can_issue && m_ready;
        grant_ops  = '0;
        req_ready  = '0;
        if (can_issue) begin
            grant_ops.a = req_a[32'(grant)*FP_W +: FP_W];
            grant_ops.b = req_b[32'(grant)*FP_W +: FP_W];
        end
        if (issue_fire) req_ready[grant] = 1'b1;
        rr_ptr_d = rr_ptr_q;
        if (issue_fire) rr_ptr_d = (grant == IDX_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
    end

    // Response side: the head tag selects which lane sees the result.
    always_comb begin
        rsp_valid = '0;
        m_rready  = !fifo_empty && rsp_ready[tag] && !reset;
        if (m_rvalid && !fifo_empty && !reset) rsp_valid[tag] = 1'b1;
        rsp_fire     = m_rvalid && m_rready;
        err_orphan_d = err_orphan_q || (m_rvalid && fifo_empty);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q     <= '0;
            err_orphan_q <= 1'b0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            err_orphan_q <= err_orphan_d;
        end
    end

    arb_tag_fifo #(
        .WIDTH (IDX_W),
        .DEPTH (MAX_INFLIGHT)
    ) u_tag_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (issue_fire),
        .push_data (grant),
        .pop       (rsp_fire),
        .head_data (tag),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign m_valid    = can_issue;
    assign m_a        = grant_ops.a;
    assign m_b        = grant_ops.b;
    assign rsp_result = m_result;
    assign rsp_flags  = m_flags;
    assign inflight   = fifo_count;
    assign err_orphan = err_orphan_q;

endmodule

// File: tb/tb_fp_mult_rr_arbiter.sv
// Randomized and directed bench for fp_mult_rr_arbiter with an in-bench multiplier stub
// and a queue-based reference model of arbitration and in-order steering.
`timescale 1ns/1ps
module tb_fp_mult_rr_arbiter;

    localparam int N  = 4;
    localparam int D  = 8;
    localparam int CW = $clog2(D) + 1;

    typedef struct {
        int          lane;
        logic [31:0] res;
        logic [2:0]  fl;
    } op_t;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
    logic [32*N-1:0] req_a, req_b;
    logic [31:0]     rsp_result, m_a, m_b, m_result;
    logic [2:0]      rsp_flags, m_flags;
    logic            m_valid, m_ready, m_rvalid, m_rready, err_orphan;
    logic [CW-1:0]   inflight;

    logic [31:0] lane_a [N];
    logic [31:0] lane_b [N];
    logic        force_rv, stub_en;
    op_t         sb[$];
    int          m_ptr;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_a[32*i +: 32] = lane_a[i];
            req_b[32*i +: 32] = lane_b[i];
        end
    end

    fp_mult_rr_arbiter #(.NUM_REQ(N), .MAX_INFLIGHT(D)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_flags(rsp_flags),
        .m_a(m_a), .m_b(m_b), .m_valid(m_valid), .m_ready(m_ready),
        .m_result(m_result), .m_flags(m_flags), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .inflight(inflight), .err_orphan(err_orphan)
    );

    // Truncating FP32 multiply for normal operands whose product stays normal.
    function automatic logic [31:0] fpmul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] p;
        logic [22:0] m;
        int          e;
        p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) begin m = p[46:24]; e = e + 1; end
        else       m = p[45:23];
        return {a[31] ^ b[31], e[7:0], m};
    endfunction

    function automatic logic [31:0] rand_fp();
        return {1'($urandom), 8'($urandom_range(150, 100)), 23'($urandom)};
    endfunction

    function automatic logic [N-1:0] one_hot(input int l);
        logic [N-1:0] v;
        v = '0;
        v[l] = 1'b1;
        return v;
    endfunction

    // Reference round robin: first requesting lane counting up from the pointer.
    function automatic int exp_grant();
        for (int k = 0; k < N; k++)
            if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    task automatic rand_ops();
        for (int i = 0; i < N; i++) begin
            lane_a[i] = rand_fp();
            lane_b[i] = rand_fp();
        end
    endtask

    // Multiplier stub: in-order results taken straight from the scoreboard queue.
    task automatic drive_mult();
        m_rvalid = force_rv || (stub_en && sb.size() > 0);
        m_result = (sb.size() > 0) ? sb[0].res : 32'hDEAD_BEEF;
        m_flags  = (sb.size() > 0) ? sb[0].fl  : 3'b111;
    endtask

    // Advance one clock, updating the reference model from the bench's own inputs.
    task automatic tick();
        int  g;
        bit  ifire, rfire;
        op_t e;
        @(negedge clk);
        g     = exp_grant();
        ifire = !reset && g >= 0 && sb.size() < D && m_ready;
        rfire = !reset && m_rvalid && sb.size() > 0 && rsp_ready[sb[0].lane];
        @(posedge clk);
        #1;
        if (reset) begin
            sb.delete();
            m_ptr = 0;
        end else begin
            if (rfire) void'(sb.pop_front());
            if (ifire) begin
                e.lane = g;
                e.res  = fpmul(lane_a[g], lane_b[g]);
                e.fl   = lane_a[g][2:0] ^ lane_b[g][2:0];
                sb.push_back(e);
                m_ptr = (g + 1) % N;
            end
        end
        drive_mult();
    endtask

    task automatic do_reset();
        reset = 1'b1; force_rv = 1'b0; req_valid = '0;
        tick();
        reset = 1'b0;
    endtask

    task automatic drain();
        req_valid = '0; stub_en = 1'b1; rsp_ready = '1; force_rv = 1'b0;
        drive_mult();
        for (int i = 0; i < 40 && sb.size() > 0; i++) tick();
        #1;
        checks++;
        if (inflight !== CW'(0)) begin
            errors++; $display("FAIL drain: inflight=%0d expected 0", inflight);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = '1; m_ready = 1'b1; rsp_ready = '1;
        stub_en = 1'b0; force_rv = 1'b1; rand_ops(); m_ptr = 0;
        drive_mult();
        tick();
        #1;
        checks++;
        if ({m_valid, req_ready, rsp_valid, m_rready} !== '0) begin
            errors++; $display("FAIL reset_handshake: got %b expected 0", {m_valid, req_ready, rsp_valid, m_rready});
        end
        checks++;
        if (inflight !== CW'(0) || err_orphan !== 1'b0) begin
            errors++; $display("FAIL reset_state: inflight=%0d orphan=%b expected 0/0", inflight, err_orphan);
        end
        force_rv = 1'b0; reset = 1'b0; req_valid = '0;
        drive_mult();
    endtask

    task automatic test_single_lane();
        req_valid = 4'b0100; m_ready = 1'b1; stub_en = 1'b0; rsp_ready = '1;
        lane_a[2] = 32'h3F80_0000; lane_b[2] = 32'h4000_0000;
        #1;
        checks++;
        if (req_ready !== 4'b0100 || m_a !== 32'h3F80_0000 || m_b !== 32'h4000_0000) begin
            errors++; $display("FAIL single_issue: ready=%b a=%h b=%h", req_ready, m_a, m_b);
        end
        tick();
        req_valid = '0; stub_en = 1'b1;
        drive_mult();
        #1;
        checks++;
        if (inflight !== CW'(1)) begin
            errors++; $display("FAIL single_inflight: got %0d expected 1", inflight);
        end
        checks++;
        if (rsp_valid !== 4'b0100 || rsp_result !== 32'h4000_0000 || rsp_flags !== 3'b000) begin
            errors++; $display("FAIL single_rsp: valid=%b res=%h fl=%b expected 0100/40000000/000",
                               rsp_valid, rsp_result, rsp_flags);
        end
        tick();
        #1;
        checks++;
        if (inflight !== CW'(0) || rsp_valid !== '0) begin
            errors++; $display("FAIL single_done: inflight=%0d rsp_valid=%b expected 0", inflight, rsp_valid);
        end
    endtask

    task automatic test_fairness();
        do_reset();
        req_valid = '1; m_ready = 1'b1; stub_en = 1'b1; rsp_ready = '1;
        for (int i = 0; i < 12; i++) begin
            rand_ops(); drive_mult();
            #1;
            checks++;
            if (req_ready !== one_hot(i % N)) begin
                errors++; $display("FAIL fair_grant[%0d]: got %b expected %b", i, req_ready, one_hot(i % N));
            end
            if (sb.size() > 0) begin
                checks++;
                if (rsp_valid !== one_hot(sb[0].lane) || rsp_result !== sb[0].res) begin
                    errors++; $display("FAIL fair_rsp[%0d]: valid=%b res=%h expected %b/%h",
                                       i, rsp_valid, rsp_result, one_hot(sb[0].lane), sb[0].res);
                end
            end
            tick();
        end
        drain();
    endtask

    task automatic test_full();
        do_reset();
        rand_ops();
        req_valid = '1; m_ready = 1'b1; rsp_ready = '0; stub_en = 1'b1;
        drive_mult();
        for (int i = 0; i < D; i++) begin
            #1;
            checks++;
            if (req_ready !== one_hot(exp_grant())) begin
                errors++; $display("FAIL full_fill[%0d]: got %b expected %b", i, req_ready, one_hot(exp_grant()));
            end
            tick();
        end
        #1;
        checks++;
        if (inflight !== CW'(D) || req_ready !== '0 || m_valid !== 1'b0 || m_rready !== 1'b0) begin
            errors++; $display("FAIL full_stop: inflight=%0d ready=%b mv=%b mrr=%b expected 8/0/0/0",
                               inflight, req_ready, m_valid, m_rready);
        end
        rsp_ready = '1;
        #1;
        checks++;
        if (m_rready !== 1'b1 || req_ready !== '0 || rsp_valid !== one_hot(sb[0].lane)) begin
            errors++; $display("FAIL full_nobypass: mrr=%b ready=%b rv=%b expected 1/0/%b",
                               m_rready, req_ready, rsp_valid, one_hot(sb[0].lane));
        end
        tick();
        rsp_ready = '0;
        #1;
        checks++;
        if (inflight !== CW'(D - 1) || req_ready !== one_hot(exp_grant())) begin
            errors++; $display("FAIL full_reissue: inflight=%0d ready=%b expected 7/%b",
                               inflight, req_ready, one_hot(exp_grant()));
        end
        tick();
        #1;
        checks++;
        if (inflight !== CW'(D)) begin
            errors++; $display("FAIL full_refill: inflight=%0d expected 8", inflight);
        end
        drain();
    endtask

    task automatic test_backpressure();
        do_reset();
        rand_ops();
        req_valid = 4'b1010; m_ready = 1'b0; stub_en = 1'b1; rsp_ready = '1;
        drive_mult();
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (m_valid !== 1'b1 || req_ready !== '0 || m_a !== lane_a[1] || m_b !== lane_b[1]) begin
                errors++; $display("FAIL bp_stall[%0d]: mv=%b ready=%b a=%h b=%h expected 1/0/%h/%h",
                                   i, m_valid, req_ready, m_a, m_b, lane_a[1], lane_b[1]);
            end
            tick();
        end
        m_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++; $display("FAIL bp_first: got %b expected 0010", req_ready);
        end
        tick();
        #1;
        checks++;
        if (req_ready !== 4'b1000) begin
            errors++; $display("FAIL bp_second: got %b expected 1000", req_ready);
        end
        tick();
        drain();
    endtask

    task automatic test_push_pop();
        do_reset();
        rand_ops();
        req_valid = 4'b0001; m_ready = 1'b1; stub_en = 1'b0; rsp_ready = '1;
        drive_mult();
        repeat (3) tick();
        req_valid = '1; stub_en = 1'b1;
        drive_mult();
        for (int i = 0; i < 12; i++) begin
            rand_ops();
            #1;
            checks++;
            if (inflight !== CW'(3) || rsp_valid !== one_hot(sb[0].lane) || rsp_result !== sb[0].res
                || rsp_flags !== sb[0].fl) begin
                errors++; $display("FAIL pushpop[%0d]: inflight=%0d rv=%b res=%h fl=%b expected 3/%b/%h/%b",
                                   i, inflight, rsp_valid, rsp_result, rsp_flags,
                                   one_hot(sb[0].lane), sb[0].res, sb[0].fl);
            end
            tick();
        end
        drain();
    endtask

    task automatic test_random();
        int  g;
        bit  ev;
        logic [N-1:0] exp_rv;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            rand_ops();
            req_valid = N'($urandom);
            m_ready   = ($urandom_range(3, 0) != 0);
            stub_en   = ($urandom_range(2, 0) != 0);
            rsp_ready = ($urandom_range(4, 0) != 0) ? '1 : N'($urandom);
            drive_mult();
            #1;
            g  = exp_grant();
            ev = (g >= 0) && (sb.size() < D);
            checks++;
            if (m_valid !== ev || req_ready !== ((ev && m_ready) ? one_hot(g) : '0) || inflight !== CW'(sb.size())) begin
                errors++; $display("FAIL rand_issue[%0d]: mv=%b ready=%b inflight=%0d expected %b/grant %0d/%0d",
                                   i, m_valid, req_ready, inflight, ev, g, sb.size());
            end
            if (ev) begin
                checks++;
                if (m_a !== lane_a[g] || m_b !== lane_b[g]) begin
                    errors++; $display("FAIL rand_ops[%0d]: a=%h b=%h expected %h/%h", i, m_a, m_b, lane_a[g], lane_b[g]);
                end
            end
            exp_rv = (m_rvalid && sb.size() > 0) ? one_hot(sb[0].lane) : '0;
            checks++;
            if (rsp_valid !== exp_rv || m_rready !== (sb.size() > 0 && rsp_ready[sb[0].lane])) begin
                errors++; $display("FAIL rand_rsp[%0d]: rv=%b mrr=%b expected rv=%b", i, rsp_valid, m_rready, exp_rv);
            end
            if (exp_rv != '0) begin
                checks++;
                if (rsp_result !== sb[0].res || rsp_flags !== sb[0].fl) begin
                    errors++; $display("FAIL rand_data[%0d]: res=%h fl=%b expected %h/%b",
                                       i, rsp_result, rsp_flags, sb[0].res, sb[0].fl);
                end
            end
            tick();
        end
        drain();
    endtask

    task automatic test_orphan();
        drain();
        force_rv = 1'b1;
        drive_mult();
        #1;
        checks++;
        if (m_rready !== 1'b0 || rsp_valid !== '0) begin
            errors++; $display("FAIL orphan_block: mrr=%b rv=%b expected 0/0", m_rready, rsp_valid);
        end
        tick();
        force_rv = 1'b0;
        drive_mult();
        #1;
        checks++;
        if (err_orphan !== 1'b1) begin
            errors++; $display("FAIL orphan_set: got %b expected 1", err_orphan);
        end
        tick(); tick();
        checks++;
        if (err_orphan !== 1'b1) begin
            errors++; $display("FAIL orphan_sticky: got %b expected 1", err_orphan);
        end
        rand_ops();
        req_valid = '1; m_ready = 1'b1; stub_en = 1'b0;
        drive_mult();
        repeat (3) tick();
        stub_en = 1'b1; reset = 1'b1;
        drive_mult();
        #1;
        checks++;
        if ({m_valid, req_ready, rsp_valid, m_rready} !== '0) begin
            errors++; $display("FAIL midreset_outputs: got %b expected 0", {m_valid, req_ready, rsp_valid, m_rready});
        end
        tick();
        reset = 1'b0; req_valid = '0;
        #1;
        checks++;
        if (inflight !== CW'(0) || err_orphan !== 1'b0 || rsp_valid !== '0) begin
            errors++; $display("FAIL midreset_state: inflight=%0d orphan=%b rv=%b expected 0/0/0",
                               inflight, err_orphan, rsp_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single_lane();
        test_fairness();
        test_full();
        test_backpressure();
        test_push_pop();
        test_random();
        test_orphan();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
